// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction-stream arbiter.
// Contents: FSM state encoding, tx word field offsets, clock-divider floor.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StBusy  = 2'd2
    } arb_state_e;

    // Tx word layout: CMD[31:28], ADDR[27:24], LEN[23:16], WDATA[15:0]
    localparam int unsigned CMD_LSB   = 28;
    localparam int unsigned CMD_W     = 4;
    localparam int unsigned ADDR_LSB  = 24;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned LEN_LSB   = 16;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned WDATA_LSB = 0;
    localparam int unsigned WDATA_W   = 16;

    // Smallest legal SPI clock divider
    localparam int unsigned CLK_DIV_MIN = 4;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   i_req  - request vector
//   i_last - index of the previously granted requester
//   o_gnt  - one-hot grant (0 when no request)
//   o_idx  - index of the granted requester
// Scans i_last+1, i_last+2, ... modulo N_REQ and takes the first set bit.
module spi_rr_pick #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [2:0]       i_last,
    output logic [N_REQ-1:0] o_gnt,
    output logic [2:0]       o_idx
);

    int   w_k;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            w_k = (int'(i_last) + i) % int'(N_REQ);
            if (!w_found && ((i_req >> w_k) & N_REQ'(1)) != '0) begin
                w_found = 1'b1;
                o_gnt   = N_REQ'(1) << w_k;
                o_idx   = 3'(w_k);
            end
        end
    end

endmodule

// File: rtl/spi_stream_arbiter.sv
// Shares one SPI master transaction stream between N_REQ requesters.
// Ports:
//   pclk_i, rst_n_i          - clock, synchronous active-low reset
//   req_tx_*                 - per-requester tx word/valid/ready
//   req_rx_*                 - broadcast rx word, per-requester rx valid/ready
//   m_tx_*, m_rx_*, eot_i    - SPI master side
//   grant_o, busy_o          - current one-hot grant, ISSUE/BUSY indicator
//   timeout_o, timeout_id_o  - watchdog abort pulse and aborted requester index
// Grant is held from arbitration through the tx handshake until eot (or abort).
module spi_stream_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned TO_W        = 16,
    parameter int unsigned TIMEOUT_CYC = 16'hFFFF
) (
    input  logic               pclk_i,
    input  logic               rst_n_i,
    input  logic [N_REQ*32-1:0] req_tx_data_i,
    input  logic [N_REQ-1:0]   req_tx_vld_i,
    output logic [N_REQ-1:0]   req_tx_rdy_o,
    output logic [31:0]        req_rx_data_o,
    output logic [N_REQ-1:0]   req_rx_vld_o,
    input  logic [N_REQ-1:0]   req_rx_rdy_i,
    output logic [31:0]        m_tx_data_o,
    output logic               m_tx_vld_o,
    input  logic               m_tx_rdy_i,
    input  logic [31:0]        m_rx_data_i,
    input  logic               m_rx_vld_i,
    output logic               m_rx_rdy_o,
    input  logic               eot_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               timeout_o,
    output logic [2:0]         timeout_id_o
);

    localparam bit            TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    arb_state_e       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [2:0]       r_gidx;
    logic [2:0]       r_last;
    logic [TO_W-1:0]  r_wdog;
    logic             r_busy;
    logic             r_timeout;
    logic [2:0]       r_timeout_id;

    logic [N_REQ-1:0] w_pick_gnt;
    logic [2:0]       w_pick_idx;
    logic [31:0]      w_sel_data;
    logic             w_sel_vld;
    logic             w_tx_hs;

    spi_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req  (req_tx_vld_i),
        .i_last (r_last),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx)
    );

    // One-hot mux of the granted requester's tx word
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (r_grant[k]) begin
                w_sel_data = req_tx_data_i[32*k +: 32];
            end
        end
    end

    assign w_sel_vld = |(req_tx_vld_i & r_grant);
    assign w_tx_hs   = (r_state == StIssue) && w_sel_vld && m_tx_rdy_i;

    always_comb begin
        m_tx_data_o  = '0;
        m_tx_vld_o   = 1'b0;
        req_tx_rdy_o = '0;
        req_rx_vld_o = '0;
        m_rx_rdy_o   = 1'b1;  // drain stray rx beats outside BUSY
        if (r_state == StIssue) begin
            m_tx_data_o  = w_sel_data;
            m_tx_vld_o   = w_sel_vld;
            req_tx_rdy_o = m_tx_rdy_i ? r_grant : '0;
        end
        if (r_state == StBusy) begin
            req_rx_vld_o = m_rx_vld_i ? r_grant : '0;
            m_rx_rdy_o   = |(req_rx_rdy_i & r_grant);
        end
    end

    assign req_rx_data_o = m_rx_data_i;
    assign grant_o       = r_grant;
    assign busy_o        = r_busy;
    assign timeout_o     = r_timeout;
    assign timeout_id_o  = r_timeout_id;

    always_ff @(posedge pclk_i) begin
        if (!rst_n_i) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last       <= 3'(N_REQ - 1);
            r_wdog       <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (|req_tx_vld_i) begin
                        r_grant <= w_pick_gnt;
                        r_gidx  <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    if (w_tx_hs) begin
                        r_wdog  <= '0;
                        r_state <= StBusy;
                    end else if (!w_sel_vld) begin
                        // Withdrawn requester moves to the back of the queue
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_last  <= r_gidx;
                        r_state <= StIdle;
                    end
                end
                StBusy: begin
                    if (r_wdog != '1) begin
                        r_wdog <= r_wdog + TO_W'(1);
                    end
                    if (eot_i) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_last  <= r_gidx;
                        r_state <= StIdle;
                    end else if (TO_EN && r_wdog == TO_LAST) begin
                        r_grant      <= '0;
                        r_busy       <= 1'b0;
                        r_last       <= r_gidx;
                        r_timeout    <= 1'b1;
                        r_timeout_id <= r_gidx;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_stream_arbiter.sv
// Directed bench for spi_stream_arbiter (N_REQ=2, TIMEOUT_CYC=8).
module tb_spi_stream_arbiter;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [63:0] req_tx_data;
    logic [1:0]  req_tx_vld;
    logic [1:0]  req_tx_rdy;
    logic [31:0] req_rx_data;
    logic [1:0]  req_rx_vld;
    logic [1:0]  req_rx_rdy;
    logic [31:0] m_tx_data;
    logic        m_tx_vld;
    logic        m_tx_rdy;
    logic [31:0] m_rx_data;
    logic        m_rx_vld;
    logic        m_rx_rdy;
    logic        eot;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout;
    logic [2:0]  timeout_id;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    spi_stream_arbiter #(
        .N_REQ       (2),
        .TO_W        (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .pclk_i        (pclk),
        .rst_n_i       (rst_n),
        .req_tx_data_i (req_tx_data),
        .req_tx_vld_i  (req_tx_vld),
        .req_tx_rdy_o  (req_tx_rdy),
        .req_rx_data_o (req_rx_data),
        .req_rx_vld_o  (req_rx_vld),
        .req_rx_rdy_i  (req_rx_rdy),
        .m_tx_data_o   (m_tx_data),
        .m_tx_vld_o    (m_tx_vld),
        .m_tx_rdy_i    (m_tx_rdy),
        .m_rx_data_i   (m_rx_data),
        .m_rx_vld_i    (m_rx_vld),
        .m_rx_rdy_o    (m_rx_rdy),
        .eot_i         (eot),
        .grant_o       (grant),
        .busy_o        (busy),
        .timeout_o     (timeout),
        .timeout_id_o  (timeout_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are then changed and outputs sampled 1ns later
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_tx_data = '0;
        req_tx_vld  = '0;
        req_rx_rdy  = 2'b11;
        m_tx_rdy    = 1'b0;
        m_rx_data   = '0;
        m_rx_vld    = 1'b0;
        eot         = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_tid", 32'(timeout_id), 32'd0);
        check("rst_m_rx_rdy", 32'(m_rx_rdy), 32'd1);
        rst_n = 1'b1;
        tick();

        // Single requester
        req_tx_data = {32'h0, 32'hA104BEEF};
        req_tx_vld  = 2'b01;
        m_tx_rdy    = 1'b1;
        #1;
        check("idle_tx_rdy", 32'(req_tx_rdy), 32'd0);
        check("idle_m_tx_vld", 32'(m_tx_vld), 32'd0);
        tick();
        check("s_grant", 32'(grant), 32'd1);
        check("s_busy", 32'(busy), 32'd1);
        check("s_m_tx_vld", 32'(m_tx_vld), 32'd1);
        check("s_m_tx_data", m_tx_data, 32'hA104BEEF);
        check("s_tx_rdy", 32'(req_tx_rdy), 32'd1);
        tick();
        req_tx_vld = 2'b00;
        m_tx_rdy   = 1'b0;
        m_rx_data  = 32'h0000_1234;
        m_rx_vld   = 1'b1;
        req_rx_rdy = 2'b01;
        #1;
        check("s_busy_m_tx_vld", 32'(m_tx_vld), 32'd0);
        check("s_rx_vld", 32'(req_rx_vld), 32'd1);
        check("s_rx_data", req_rx_data, 32'h0000_1234);
        check("s_m_rx_rdy", 32'(m_rx_rdy), 32'd1);
        req_rx_rdy = 2'b10;
        #1;
        check("s_m_rx_rdy_other", 32'(m_rx_rdy), 32'd0);
        req_rx_rdy = 2'b11;
        tick();
        m_rx_vld = 1'b0;
        eot      = 1'b1;
        tick();
        eot = 1'b0;
        check("s_eot_grant", 32'(grant), 32'd0);
        check("s_eot_busy", 32'(busy), 32'd0);

        // Contention after reset: expect 0,1,0,1
        rst_n = 1'b0;
        tick();
        rst_n       = 1'b1;
        req_tx_data = {32'h2222_2222, 32'h1111_1111};
        req_tx_vld  = 2'b11;
        m_tx_rdy    = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("c%0d_grant", t), 32'(grant), (t % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("c%0d_data", t), m_tx_data,
                  (t % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
            tick();
            eot = 1'b1;
            tick();
            eot = 1'b0;
            check($sformatf("c%0d_idle", t), 32'(grant), 32'd0);
        end

        // Timeout on req1
        req_tx_vld = 2'b10;
        tick();
        check("to_grant", 32'(grant), 32'd2);
        tick();
        req_tx_vld = 2'b00;
        m_tx_rdy   = 1'b0;
        for (int c = 1; c < 8; c++) begin
            tick();
            check($sformatf("to_quiet%0d", c), 32'(timeout), 32'd0);
        end
        tick();
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_id", 32'(timeout_id), 32'd1);
        check("to_grant0", 32'(grant), 32'd0);
        check("to_busy0", 32'(busy), 32'd0);
        req_tx_vld = 2'b11;
        tick();
        check("to_pulse_end", 32'(timeout), 32'd0);
        check("to_next_grant", 32'(grant), 32'd1);

        // Withdraw in ISSUE (m_tx_rdy still 0)
        req_tx_vld = 2'b00;
        tick();
        check("wd_grant", 32'(grant), 32'd0);
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_m_tx_vld", 32'(m_tx_vld), 32'd0);

        // Stray rx in IDLE
        m_rx_vld = 1'b1;
        #1;
        check("stray_m_rx_rdy", 32'(m_rx_rdy), 32'd1);
        check("stray_rx_vld", 32'(req_rx_vld), 32'd0);
        m_rx_vld = 1'b0;

        // Rx beat coincident with eot
        req_tx_vld = 2'b01;
        m_tx_rdy   = 1'b1;
        tick();
        check("re_grant", 32'(grant), 32'd1);
        tick();
        req_tx_vld = 2'b00;
        m_tx_rdy   = 1'b0;
        m_rx_data  = 32'h0000_CAFE;
        m_rx_vld   = 1'b1;
        eot        = 1'b1;
        #1;
        check("re_rx_vld", 32'(req_rx_vld), 32'd1);
        check("re_rx_data", req_rx_data, 32'h0000_CAFE);
        tick();
        m_rx_vld = 1'b0;
        eot      = 1'b0;
        check("re_grant0", 32'(grant), 32'd0);
        check("re_timeout", 32'(timeout), 32'd0);

        // Eot on the timeout cycle: eot wins
        req_tx_vld = 2'b10;
        m_tx_rdy   = 1'b1;
        tick();
        check("et_grant", 32'(grant), 32'd2);
        tick();
        req_tx_vld = 2'b00;
        m_tx_rdy   = 1'b0;
        for (int c = 1; c < 8; c++) begin
            tick();
        end
        eot = 1'b1;
        tick();
        eot = 1'b0;
        check("et_no_pulse", 32'(timeout), 32'd0);
        check("et_grant0", 32'(grant), 32'd0);
        tick();
        check("et_no_pulse2", 32'(timeout), 32'd0);

        // Reset mid-BUSY; without reset req1 would win next
        req_tx_vld = 2'b01;
        m_tx_rdy   = 1'b1;
        tick();
        tick();
        req_tx_vld = 2'b00;
        m_tx_rdy   = 1'b0;
        check("rb_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rb_grant", 32'(grant), 32'd0);
        check("rb_busy", 32'(busy), 32'd0);
        check("rb_timeout", 32'(timeout), 32'd0);
        req_tx_vld = 2'b11;
        tick();
        check("rb_next_grant", 32'(grant), 32'd1);
        req_tx_vld = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
